// File: rtl/intr_controller.sv
// intr_controller: prioritized memory-mapped interrupt controller that sits in
// front of the MCU's single intr input.
//
// Ports:
//   sys_clk   system clock, all state changes on the rising edge
//   reset     asynchronous active-low reset
//   irq_in    NUM_SRC asynchronous request lines, rising-edge sensitive
//   io_cs     register chip select
//   io_rd     read strobe
//   io_wr     write strobe
//   io_addr   register select: 0 PEND, 1 MASK, 2 VECT, 3 EOI
//   io_wdata  write data
//   io_rdata  combinational read data, 0 unless io_cs & io_rd
//   intr      registered interrupt request to the MCU
//   int_ack   one-cycle acknowledge from the MCU
//
// FSM states:
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | nothing requested; arbitrate eligible sources each cycle
//   ST_REQ     | intr high, waiting for int_ack or for the request to vanish
//   ST_SERVICE | ISR running on the vectored source; waiting for EOI write
module intr_controller #(
  parameter int ID_W = 3,
  localparam int NUM_SRC = 2**ID_W
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               io_cs,
  input  logic               io_rd,
  input  logic               io_wr,
  input  logic [1:0]         io_addr,
  input  logic [31:0]        io_wdata,
  output logic [31:0]        io_rdata,
  output logic               intr,
  input  logic               int_ack
);

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_VECT = 2'd2;
  localparam logic [1:0] ADDR_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] s_a;
  logic [NUM_SRC-1:0] s_b;
  logic [NUM_SRC-1:0] s_c;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] w1c_clr;
  logic [ID_W-1:0]    winner;
  logic [31:0]        vector;
  logic               wr_en;
  logic               wr_pend;
  logic               wr_mask;
  logic               wr_eoi;
  logic               ack_take;
  logic               unused_wdata;

  // Only the low NUM_SRC bits of write data carry meaning.
  assign unused_wdata = ^io_wdata[31:NUM_SRC];

  assign wr_en   = io_cs & io_wr;
  assign wr_pend = wr_en & (io_addr == ADDR_PEND);
  assign wr_mask = wr_en & (io_addr == ADDR_MASK);
  assign wr_eoi  = wr_en & (io_addr == ADDR_EOI);

  assign rise     = s_b & ~s_c;
  assign eligible = pending & ~mask;

  // Lowest index wins: scan downward so the last assignment is the lowest.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // An ack arriving in the one cycle after a mask write has already withdrawn
  // the request has no valid winner, so it is treated like a stray ack.
  assign ack_take = (state == ST_REQ) & int_ack & (|eligible);
  assign ack_clr  = ack_take ? (NUM_SRC'(1) << winner) : '0;
  assign w1c_clr  = wr_pend ? io_wdata[NUM_SRC-1:0] : '0;

  // Synchronizer, edge detect and pending latch; a fresh rise beats any clear.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      s_a     <= '0;
      s_b     <= '0;
      s_c     <= '0;
      pending <= '0;
    end else begin
      s_a     <= irq_in;
      s_b     <= s_a;
      s_c     <= s_b;
      pending <= (pending & ~(ack_clr | w1c_clr)) | rise;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      mask <= '1;
    end else if (wr_mask) begin
      mask <= io_wdata[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      intr   <= 1'b0;
      vector <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state <= ST_REQ;
            intr  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ack_take) begin
            vector <= {1'b1, {(31-ID_W){1'b0}}, winner};
            intr   <= 1'b0;
            state  <= ST_SERVICE;
          end else if (!(|eligible)) begin
            intr  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          intr <= 1'b0;
          if (wr_eoi) begin
            vector[31] <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          intr  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_cs & io_rd) begin
      case (io_addr)
        ADDR_PEND: io_rdata = {{(32-NUM_SRC){1'b0}}, pending};
        ADDR_MASK: io_rdata = {{(32-NUM_SRC){1'b0}}, mask};
        ADDR_VECT: io_rdata = vector;
        default:   io_rdata = '0;
      endcase
    end
  end

endmodule
